// File: rtl/pixel_pingpong_mem.sv
// Double-buffered pixel store: the writer fills one bank with LANES scattered
// pixels per cycle while the reader drains the other bank with LANES
// independent addresses per cycle. WDONE/RDONE pulses hand banks across.
module pixel_pingpong_mem #(
    parameter int LANES = 4,
    parameter int PIX_W = 8,
    parameter int DEPTH = 192,
    parameter int AW    = 8
) (
    input  logic                   I_PMEM_HCLK,
    input  logic                   I_PMEM_HRESET_N,
    input  logic                   I_PMEM_WRITE,
    input  logic [LANES*AW-1:0]    I_PMEM_WADDR,
    input  logic [LANES*PIX_W-1:0] I_PMEM_WDATA,
    input  logic [LANES-1:0]       I_PMEM_WBE,
    input  logic                   I_PMEM_WDONE,
    output logic                   O_PMEM_WREADY,
    input  logic                   I_PMEM_READ,
    input  logic [LANES*AW-1:0]    I_PMEM_RADDR,
    output logic [LANES*PIX_W-1:0] O_PMEM_RDATA,
    output logic                   O_PMEM_RVALID,
    input  logic                   I_PMEM_RDONE,
    output logic                   O_PMEM_RREADY,
    output logic                   O_PMEM_ERR,
    input  logic                   I_PMEM_ERR_CLR
);

    // One extra bit so DEPTH == 2^AW still compares correctly.
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic             wr_sel_reg, wr_sel_next;
    logic             rd_sel_reg, rd_sel_next;
    logic [1:0]       full_reg, full_next;
    logic             err_reg, err_next;
    logic             rvalid_reg;
    logic [PIX_W-1:0] rdata_reg [LANES];

    // Two banks; contents are never reset.
    logic [PIX_W-1:0] mem [0:1][0:DEPTH-1];

    logic             wready, rready;
    logic             wr_accept, rd_accept;
    logic [LANES-1:0] wr_in_range, wr_lane_en, wr_oor;
    logic [LANES-1:0] rd_in_range, rd_oor;
    logic [AW-1:0]    wr_idx [LANES];
    logic [AW-1:0]    rd_idx [LANES];
    logic [PIX_W-1:0] wdata_lane [LANES];
    logic             any_err;

    assign wready    = ~full_reg[wr_sel_reg];
    assign rready    = full_reg[rd_sel_reg];
    assign wr_accept = I_PMEM_WRITE & wready;
    assign rd_accept = I_PMEM_READ & rready;

    // Per-lane address decode; out-of-range indices are clipped to 0 so the
    // array is never addressed outside its bounds.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [AW-1:0] waddr_l;
            logic [AW-1:0] raddr_l;
            assign waddr_l         = I_PMEM_WADDR[gi*AW +: AW];
            assign raddr_l         = I_PMEM_RADDR[gi*AW +: AW];
            assign wr_in_range[gi] = {1'b0, waddr_l} < DEPTH_LIM;
            assign rd_in_range[gi] = {1'b0, raddr_l} < DEPTH_LIM;
            assign wr_idx[gi]      = wr_in_range[gi] ? waddr_l : '0;
            assign rd_idx[gi]      = rd_in_range[gi] ? raddr_l : '0;
            assign wr_lane_en[gi]  = wr_accept & I_PMEM_WBE[gi] & wr_in_range[gi];
            assign wr_oor[gi]      = I_PMEM_WRITE & I_PMEM_WBE[gi] & ~wr_in_range[gi];
            assign rd_oor[gi]      = rd_accept & ~rd_in_range[gi];
            assign wdata_lane[gi]  = I_PMEM_WDATA[gi*PIX_W +: PIX_W];
            assign O_PMEM_RDATA[gi*PIX_W +: PIX_W] = rdata_reg[gi];
        end
    endgenerate

    assign any_err = (I_PMEM_WRITE & ~wready) | (|wr_oor) | (|rd_oor)
                   | (I_PMEM_WDONE & ~wready) | (I_PMEM_RDONE & ~rready);

    // Next-state for bank selects, frame-complete flags and the sticky error.
    always_comb begin
        full_next   = full_reg;
        wr_sel_next = wr_sel_reg;
        rd_sel_next = rd_sel_reg;
        err_next    = err_reg;
        // WDONE and RDONE can never target the same bank, so both may apply.
        if (I_PMEM_WDONE && wready) begin
            full_next[wr_sel_reg] = 1'b1;
            wr_sel_next           = ~wr_sel_reg;
        end
        if (I_PMEM_RDONE && rready) begin
            full_next[rd_sel_reg] = 1'b0;
            rd_sel_next           = ~rd_sel_reg;
        end
        if (I_PMEM_ERR_CLR) err_next = 1'b0;
        if (any_err)        err_next = 1'b1;
    end

    // Control state register.
    always_ff @(posedge I_PMEM_HCLK or negedge I_PMEM_HRESET_N) begin
        if (!I_PMEM_HRESET_N) begin
            wr_sel_reg <= 1'b0;
            rd_sel_reg <= 1'b0;
            full_reg   <= 2'b00;
            err_reg    <= 1'b0;
        end else begin
            wr_sel_reg <= wr_sel_next;
            rd_sel_reg <= rd_sel_next;
            full_reg   <= full_next;
            err_reg    <= err_next;
        end
    end

    // Pixel writes; later lanes override earlier ones on an address collision.
    always_ff @(posedge I_PMEM_HCLK) begin
        for (int k = 0; k < LANES; k++) begin
            if (wr_lane_en[k]) mem[wr_sel_reg][wr_idx[k]] <= wdata_lane[k];
        end
    end

    // Registered read: out-of-range lanes return zero, data holds when idle.
    always_ff @(posedge I_PMEM_HCLK or negedge I_PMEM_HRESET_N) begin
        if (!I_PMEM_HRESET_N) begin
            rvalid_reg <= 1'b0;
            for (int k = 0; k < LANES; k++) rdata_reg[k] <= '0;
        end else begin
            rvalid_reg <= rd_accept;
            if (rd_accept) begin
                for (int k = 0; k < LANES; k++)
                    rdata_reg[k] <= rd_in_range[k] ? mem[rd_sel_reg][rd_idx[k]] : '0;
            end
        end
    end

    assign O_PMEM_WREADY = wready;
    assign O_PMEM_RREADY = rready;
    assign O_PMEM_RVALID = rvalid_reg;
    assign O_PMEM_ERR    = err_reg;

endmodule

// File: tb/tb_pixel_pingpong_mem.sv
// Directed bench for pixel_pingpong_mem: a 4-lane/8-bit instance and a
// 2-lane/16-bit instance, read results checked against a scoreboard queue.
module tb_pixel_pingpong_mem;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-lane, 8-bit, DEPTH 192 instance
    logic        a_write, a_wdone, a_read, a_rdone, a_err_clr;
    logic [31:0] a_waddr, a_wdata, a_raddr, a_rdata;
    logic [3:0]  a_wbe;
    logic        a_wready, a_rready, a_rvalid, a_err;

    // 2-lane, 16-bit, DEPTH 64 instance
    logic        b_write, b_wdone, b_read, b_rdone, b_err_clr;
    logic [11:0] b_waddr, b_raddr;
    logic [31:0] b_wdata, b_rdata;
    logic [1:0]  b_wbe;
    logic        b_wready, b_rready, b_rvalid, b_err;

    int checks = 0;
    int failures = 0;
    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    logic [31:0] e;

    pixel_pingpong_mem #(.LANES(4), .PIX_W(8), .DEPTH(192), .AW(8)) dut_a (
        .I_PMEM_HCLK(clk), .I_PMEM_HRESET_N(rst_n),
        .I_PMEM_WRITE(a_write), .I_PMEM_WADDR(a_waddr), .I_PMEM_WDATA(a_wdata),
        .I_PMEM_WBE(a_wbe), .I_PMEM_WDONE(a_wdone), .O_PMEM_WREADY(a_wready),
        .I_PMEM_READ(a_read), .I_PMEM_RADDR(a_raddr), .O_PMEM_RDATA(a_rdata),
        .O_PMEM_RVALID(a_rvalid), .I_PMEM_RDONE(a_rdone), .O_PMEM_RREADY(a_rready),
        .O_PMEM_ERR(a_err), .I_PMEM_ERR_CLR(a_err_clr)
    );

    pixel_pingpong_mem #(.LANES(2), .PIX_W(16), .DEPTH(64), .AW(6)) dut_b (
        .I_PMEM_HCLK(clk), .I_PMEM_HRESET_N(rst_n),
        .I_PMEM_WRITE(b_write), .I_PMEM_WADDR(b_waddr), .I_PMEM_WDATA(b_wdata),
        .I_PMEM_WBE(b_wbe), .I_PMEM_WDONE(b_wdone), .O_PMEM_WREADY(b_wready),
        .I_PMEM_READ(b_read), .I_PMEM_RADDR(b_raddr), .O_PMEM_RDATA(b_rdata),
        .O_PMEM_RVALID(b_rvalid), .I_PMEM_RDONE(b_rdone), .O_PMEM_RREADY(b_rready),
        .O_PMEM_ERR(b_err), .I_PMEM_ERR_CLR(b_err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock, then score any read data that came back.
    task automatic step();
        @(posedge clk);
        #1;
        if (a_rvalid === 1'b1) begin
            if (a_q.size() == 0) chk1("a_unexpected_rvalid", a_rvalid, 1'b0);
            else begin
                e = a_q.pop_front();
                chk("a_rdata", a_rdata, e);
                $display("A read  rdata=%h expected=%h", a_rdata, e);
            end
        end
        if (b_rvalid === 1'b1) begin
            if (b_q.size() == 0) chk1("b_unexpected_rvalid", b_rvalid, 1'b0);
            else begin
                e = b_q.pop_front();
                chk("b_rdata", b_rdata, e);
                $display("B read  rdata=%h expected=%h", b_rdata, e);
            end
        end
    endtask

    initial begin
        a_write = 0; a_wdone = 0; a_read = 0; a_rdone = 0; a_err_clr = 0;
        a_waddr = '0; a_wdata = '0; a_raddr = '0; a_wbe = '0;
        b_write = 0; b_wdone = 0; b_read = 0; b_rdone = 0; b_err_clr = 0;
        b_waddr = '0; b_wdata = '0; b_raddr = '0; b_wbe = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("rst_rdata", a_rdata, 32'h0);
        chk1("rst_rvalid", a_rvalid, 1'b0);
        chk1("rst_err", a_err, 1'b0);
        chk1("rst_wready", a_wready, 1'b1);
        chk1("rst_rready", a_rready, 1'b0);

        // 2-lane 16-bit instance: write, swap, read back reversed
        b_write = 1; b_wbe = 2'b11; b_waddr = {6'd6, 6'd5}; b_wdata = 32'hA1B1_A0B0;
        step();
        b_write = 0; b_wbe = 0;
        b_wdone = 1; step(); b_wdone = 0;
        chk1("b_rready_after_wdone", b_rready, 1'b1);
        b_read = 1; b_raddr = {6'd5, 6'd6}; b_q.push_back(32'hA0B0_A1B1);
        step(); b_read = 0;
        chk1("b_rvalid", b_rvalid, 1'b1);
        chk1("b_err", b_err, 1'b0);

        // Scenario 1: lanes 0..3 at addrs 5..8, swap, read back reversed
        a_write = 1; a_wbe = 4'hF; a_waddr = 32'h0807_0605; a_wdata = 32'hA3A2_A1A0;
        step();
        a_write = 0; a_wbe = 0;
        chk1("s1_rready_before_wdone", a_rready, 1'b0);
        a_wdone = 1; step(); a_wdone = 0;
        chk1("s1_rready_after_wdone", a_rready, 1'b1);
        chk1("s1_wready_after_wdone", a_wready, 1'b1);
        a_read = 1; a_raddr = 32'h0506_0708; a_q.push_back(32'hA0A1_A2A3);
        step(); a_read = 0;
        chk1("s1_rvalid", a_rvalid, 1'b1);
        chk1("s1_err", a_err, 1'b0);
        step();
        chk1("s1_rvalid_single", a_rvalid, 1'b0);

        // Lane collision into bank1: highest lane wins
        a_write = 1; a_wbe = 4'hF; a_waddr = 32'h0A0A_0A0A; a_wdata = 32'h4433_2211;
        step();
        a_write = 0; a_wbe = 0;
        a_rdone = 1; a_wdone = 1; step(); a_rdone = 0; a_wdone = 0;
        chk1("coll_rready", a_rready, 1'b1);
        chk1("coll_wready", a_wready, 1'b1);
        a_read = 1; a_raddr = 32'h0A0A_0A0A; a_q.push_back(32'h4444_4444);
        step(); a_read = 0;
        a_rdone = 1; step(); a_rdone = 0;
        chk1("coll_rready_released", a_rready, 1'b0);
        chk1("coll_err", a_err, 1'b0);

        // Ping-pong: fill bank0 with N at addr N
        a_write = 1; a_wbe = 4'hF;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                a_waddr[k*8 +: 8] = 8'(4*i + k);
                a_wdata[k*8 +: 8] = 8'(4*i + k);
            end
            step();
        end
        a_write = 0; a_wbe = 0;
        a_wdone = 1; step(); a_wdone = 0;
        chk1("pp_rready_bank0", a_rready, 1'b1);
        // Fill bank1 with 0x80|N while reading bank0 every cycle
        a_write = 1; a_wbe = 4'hF; a_read = 1;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                a_waddr[k*8 +: 8] = 8'(4*i + k);
                a_wdata[k*8 +: 8] = 8'(8'h80 | (4*i + k));
                a_raddr[k*8 +: 8] = 8'(15 - (4*i + k));
                e[k*8 +: 8]       = 8'(15 - (4*i + k));
            end
            a_q.push_back(e);
            step();
        end
        a_write = 0; a_wbe = 0; a_read = 0;
        a_wdone = 1; step(); a_wdone = 0;
        chk1("pp_wready_both_full", a_wready, 1'b0);
        chk1("pp_rready_both_full", a_rready, 1'b1);
        a_rdone = 1; step(); a_rdone = 0;
        chk1("pp_rready_bank1", a_rready, 1'b1);
        chk1("pp_wready_bank0_free", a_wready, 1'b1);
        a_read = 1;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                a_raddr[k*8 +: 8] = 8'(4*i + k);
                e[k*8 +: 8]       = 8'(8'h80 | (4*i + k));
            end
            a_q.push_back(e);
            step();
        end
        a_read = 0;
        a_rdone = 1; step(); a_rdone = 0;
        chk1("pp_err", a_err, 1'b0);

        // Errors: out-of-range write lane dropped, in-range lane kept
        a_write = 1; a_wbe = 4'b0011; a_waddr = 32'h0000_03C8; a_wdata = 32'h0000_5AEE;
        step();
        a_write = 0; a_wbe = 0;
        chk1("err_write_oor", a_err, 1'b1);
        a_err_clr = 1; step(); a_err_clr = 0;
        chk1("err_clr", a_err, 1'b0);
        a_read = 1; a_raddr = 32'h0; step(); a_read = 0;
        chk1("err_read_not_ready_rvalid", a_rvalid, 1'b0);
        chk1("err_read_not_ready_err", a_err, 1'b0);
        a_rdone = 1; step(); a_rdone = 0;
        chk1("err_rdone_not_ready", a_err, 1'b1);
        a_rdone = 1; a_err_clr = 1; step(); a_rdone = 0; a_err_clr = 0;
        chk1("err_set_wins", a_err, 1'b1);
        a_err_clr = 1; step(); a_err_clr = 0;
        chk1("err_clr2", a_err, 1'b0);
        a_wdone = 1; step(); a_wdone = 0;
        a_read = 1; a_raddr = 32'h0303_03FA; a_q.push_back(32'h5A5A_5A00);
        step(); a_read = 0;
        chk1("err_read_oor", a_err, 1'b1);
        a_err_clr = 1; step(); a_err_clr = 0;
        a_wdone = 1; step(); a_wdone = 0;
        chk1("err_both_full_wready", a_wready, 1'b0);
        chk1("err_both_full_clean", a_err, 1'b0);
        a_write = 1; a_wbe = 4'b0001; a_waddr = 32'h3; a_wdata = 32'h77;
        step();
        a_write = 0; a_wbe = 0;
        chk1("err_write_not_ready", a_err, 1'b1);
        a_err_clr = 1; step(); a_err_clr = 0;
        a_wdone = 1; step(); a_wdone = 0;
        chk1("err_wdone_not_ready", a_err, 1'b1);

        // Reset mid-read clears RVALID/RDATA asynchronously
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        a_write = 1; a_wbe = 4'hF; a_waddr = 32'h0807_0605; a_wdata = 32'hB3B2_B1B0;
        step();
        a_write = 0; a_wbe = 0;
        a_wdone = 1; step(); a_wdone = 0;
        a_read = 1; a_raddr = 32'h0506_0708; a_q.push_back(32'hB0B1_B2B3);
        step(); a_read = 0;
        chk1("mid_rvalid_before_reset", a_rvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("mid_rvalid_async", a_rvalid, 1'b0);
        chk("mid_rdata_async", a_rdata, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk1("mid_wready", a_wready, 1'b1);
        chk1("mid_rready", a_rready, 1'b0);
        chk1("mid_err", a_err, 1'b0);

        chk("a_queue_drained", 32'(a_q.size()), 32'd0);
        chk("b_queue_drained", 32'(b_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_pingpong_mem.md
# pixel_pingpong_mem

Parametrised, double-buffered pixel store between the AHB-side input pixel core and the rotate datapath. The writer fills one bank with LANES pixels per cycle at scattered byte addresses. The reader concurrently drains the other bank with LANES independent read addresses per cycle. A bank-swap handshake (done pulses plus ready flags) replaces the single-bank write/read interlock and lets frame N+1 load while frame N is rotated.

## Interface
- LANES, 4: pixels written/read per cycle
- PIX_W, 8: bits per pixel
- DEPTH, 192: pixels per bank
- AW, 8: address bits per lane, must satisfy 2^AW >= DEPTH

- I_PMEM_HCLK  in  1  clock
- I_PMEM_HRESET_N  in  1  asynchronous active-low reset
- I_PMEM_WRITE  in  1  write strobe, lanes qualified by WBE
- I_PMEM_WADDR  in  LANES*AW  lane k address at [k*AW +: AW]
- I_PMEM_WDATA  in  LANES*PIX_W  lane k pixel at [k*PIX_W +: PIX_W]
- I_PMEM_WBE  in  LANES  per-lane write enable
- I_PMEM_WDONE  in  1  pulse: write bank complete, request swap
- O_PMEM_WREADY  out  1  write bank free to fill
- I_PMEM_READ  in  1  read request
- I_PMEM_RADDR  in  LANES*AW  lane k read address
- O_PMEM_RDATA  out  LANES*PIX_W  registered read pixels
- O_PMEM_RVALID  out  1  RDATA valid this cycle
- I_PMEM_RDONE  in  1  pulse: read bank consumed, release it
- O_PMEM_RREADY  out  1  read bank holds a complete frame
- O_PMEM_ERR  out  1  sticky error flag
- I_PMEM_ERR_CLR  in  1  clears O_PMEM_ERR

## Operation
- Storage: two banks of DEPTH x PIX_W.
- Control registers:
  - wr_sel: bank being filled.
  - rd_sel: bank being drained.
  - full[1:0]: per-bank frame-complete flags.
- WREADY = !full[wr_sel]. RREADY = full[rd_sel].
- Write accept:
  - Lane k writes bank wr_sel when WRITE & WBE[k] & WREADY & WADDR_k < DEPTH.
  - Lane collision on the same address in one cycle: the highest-numbered lane wins.
- Write while !WREADY: no memory change, ERR set.
- WDONE while WREADY: full[wr_sel] <= 1 and wr_sel toggles. WDONE while !WREADY: ignored, ERR set.
- Read accept: READ & RREADY. Lane k returns bank rd_sel at RADDR_k.
- Read while !RREADY: not accepted. RVALID stays 0, RDATA holds.
- Out-of-range address (>= DEPTH):
  - Write lane dropped, ERR set.
  - Read lane returns 0, ERR set. Other lanes are unaffected.
- RDONE while RREADY: full[rd_sel] <= 0 and rd_sel toggles. RDONE while !RREADY: ignored, ERR set.
- WDONE and RDONE in the same cycle: both apply independently. They always target different banks, because wr_sel==rd_sel implies at most one of WREADY/RREADY is high.
- Read and write never alias, since an accepted read and an accepted write always hit different banks. No bypass is needed.
- ERR:
  - Set by any error condition above.
  - Cleared by ERR_CLR.
  - Set wins over clear in the same cycle.
- Bank states per bank: EMPTY (full=0) -> filling (wr_sel points here) -> FULL (WDONE) -> draining (rd_sel points here) -> EMPTY (RDONE).

## Timing
- Reset (asynchronous assert, synchronous release):
  - wr_sel=0, rd_sel=0, full=2'b00.
  - RDATA=0, RVALID=0, ERR=0.
  - WREADY=1, RREADY=0.
  - Memory contents are not reset and are undefined until written.
- Write latency: data is in the array at the clock edge where it is accepted. It is readable once the bank has swapped to the read side.
- Read latency: 1 cycle. Request accepted at edge t gives RDATA/RVALID=1 after edge t+1. RVALID is a single-cycle echo of each accepted READ.
- Swap latency: WDONE at edge t gives RREADY=1 after t+1 if that bank becomes rd_sel. WREADY reflects the new wr_sel bank immediately after t+1.
- Back-to-back: WDONE may be followed by WRITE on the next cycle if the other bank is free. A full pipeline sustains one WRITE and one READ per cycle.
- Reset mid-frame: all in-flight reads are discarded (RVALID=0), both banks are marked EMPTY, and the partial frame is lost.
- Both banks FULL: WREADY=0 until RDONE. The writer stalls.

## Test plan
- Reset, then write lanes {0,1,2,3} = {0xA0,0xA1,0xA2,0xA3} at addrs {5,6,7,8}, then WDONE, then READ at addrs {8,7,6,5} -> RREADY=1 one cycle after WDONE; RDATA={0xA0,0xA1,0xA2,0xA3} (lane3..lane0) with RVALID one cycle after READ; ERR=0.
- Lane collision: WBE=4'b1111, all addrs=10, data {0x11,0x22,0x33,0x44} -> readback of addr 10 returns 0x44.
- Ping-pong: fill bank0 with 0x0N at addr N; WDONE; fill bank1 with 0x8N while reading bank0 every cycle -> bank0 data exact; WDONE with RREADY still on bank0 -> WREADY=0; RDONE -> rd_sel=1, RREADY=1, WREADY=1; reads return 0x8N.
- Errors: write addr 200 (DEPTH=192) -> no change, ERR=1; READ with RREADY=0 -> RVALID=0, ERR unchanged; RDONE with RREADY=0 -> ERR=1; ERR_CLR -> ERR=0 next cycle.
- Reset asserted mid-read (READ accepted the cycle before) -> RVALID=0 and RDATA=0 immediately, without waiting for a clock; WREADY=1, RREADY=0 after release.
- Parameter sweep LANES=2, PIX_W=16, DEPTH=64, AW=6: repeat scenario 1 with 16-bit pixels -> identical behaviour.
